product_22_4_22: RTL and testbench

Sequential shift-and-add multiplier: the inverse arithmetic counterpart of the bit-serial restoring divider used in the integer-factorization test project. It multiplies a 22-bit multiplicand by a 4-bit multiplier and returns a 22-bit product, plus an overflow flag. It uses the same single-pulse `start` / level `result_ready` handshake as the divider. A factorization checker can therefore verify `quotient * divisor + remainder == dividend` with an interchangeable call sequence.

---
 rtl/product_22_4_22.sv | 117 +++++++++++
 tb/tb_product_22_4_22.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/product_22_4_22.sv
// Bit-serial shift-and-add multiplier with start/result_ready handshake.
// Optional overflow flag and wide accumulator built when PRODUCT_OVERFLOW_EN is defined.
module product_22_4_22 #(
   parameter int unsigned WIDTH_A = 22,
   parameter int unsigned WIDTH_B = 4,
   parameter int unsigned WIDTH_P = 22
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [WIDTH_A-1:0] multiplicand,
   input  logic [WIDTH_B-1:0] orgmul,
   output logic [WIDTH_P-1:0] result,
   output logic               overflow,
   output logic               result_ready
);

`ifdef PRODUCT_OVERFLOW_EN
   localparam int unsigned ACCW = WIDTH_A + WIDTH_B;
`else
   localparam int unsigned ACCW = WIDTH_P;
`endif
   localparam int unsigned IW = $clog2(WIDTH_B + 1);

   typedef enum logic [1:0] {
      READY     = 2'd0,
      INITS     = 2'd1,
      WAITING   = 2'd2,
      RESTARTED = 2'd3
   } state_t;

   state_t             state_q, state_d;
   logic [IW-1:0]      i_q, i_d;
   logic [ACCW-1:0]    acc_q, acc_d;
   logic [ACCW-1:0]    mcand_q, mcand_d;
   logic [WIDTH_B-1:0] mplier_q, mplier_d;
   logic [WIDTH_P-1:0] result_q, result_d;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= READY;
         i_q      <= '0;
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         i_q      <= i_d;
         acc_q    <= acc_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         result_q <= result_d;
      end
   end

`ifdef PRODUCT_OVERFLOW_EN
   logic overflow_q, overflow_d;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) overflow_q <= 1'b0;
      else       overflow_q <= overflow_d;
   end

   always_comb begin
      overflow_d = overflow_q;
      if (!start && state_q == WAITING && (i_q == '0 || mplier_q == '0))
         overflow_d = |acc_q[ACCW-1:WIDTH_P];
   end

   assign overflow = overflow_q;
`else
   assign overflow = 1'b0;
`endif

   always_comb begin
      state_d  = state_q;
      i_d      = i_q;
      acc_d    = acc_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      result_d = result_q;
      unique case (state_q)
         READY: ;
         INITS: begin
            i_d      = IW'(WIDTH_B);
            acc_d    = '0;
            mcand_d  = ACCW'(multiplicand);
            mplier_d = orgmul;
            state_d  = RESTARTED;
         end
         RESTARTED: state_d = WAITING;
         WAITING: begin
            if (i_q == '0 || mplier_q == '0) begin
               result_d = acc_q[WIDTH_P-1:0];
               state_d  = READY;
            end else begin
               acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
               mcand_d  = mcand_q << 1;
               mplier_d = mplier_q >> 1;
               i_d      = i_q - IW'(1);
               state_d  = RESTARTED;
            end
         end
         default: state_d = READY;
      endcase
      // start abandons the current job: result stays, INITS reloads next edge
      if (start) begin
         state_d  = INITS;
         result_d = result_q;
      end
   end

   assign result       = result_q;
   assign result_ready = (state_q == READY) && !start;

endmodule

// File: tb/tb_product_22_4_22.sv
// Self-checking bench for product_22_4_22: directed cases plus random round trip.
module tb_product_22_4_22;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [21:0] multiplicand;
   logic [3:0]  orgmul;
   logic [21:0] result;
   logic        overflow;
   logic        result_ready;

   int checks = 0;
   int errors = 0;
   logic [21:0] last_result = '0;

   product_22_4_22 #(.WIDTH_A(22), .WIDTH_B(4), .WIDTH_P(22)) dut (
      .clk(clk), .reset(reset), .start(start), .multiplicand(multiplicand),
      .orgmul(orgmul), .result(result), .overflow(overflow),
      .result_ready(result_ready)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Drive start for n cycles; only the last start cycle carries the real operands.
   task automatic start_op(input logic [21:0] a, input logic [3:0] b, input int n);
      for (int j = 0; j < n; j++) begin
         @(negedge clk);
         start = 1'b1;
         if (j == n - 1) begin
            multiplicand = a;
            orgmul       = b;
         end else begin
            multiplicand = 22'($urandom);
            orgmul       = 4'($urandom);
         end
         #1 check("ready_low_at_start", result_ready, 0);
      end
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic finish_op(input string tag, input logic [21:0] a, input logic [3:0] b,
                            input bit roundtrip);
      longint unsigned p;
      int k, exp_lat, lat;
      logic [21:0] exp_res;
      logic        exp_ovf;
      k = 0;
      for (int unsigned j = 0; j < 4; j++) if (b[j]) k = int'(j) + 1;
      exp_lat = 4 + 2 * k;
      p       = longint'(a) * longint'(b);
      exp_res = p[21:0];
`ifdef PRODUCT_OVERFLOW_EN
      exp_ovf = (p >> 22) != 0;
`else
      exp_ovf = 1'b0;
`endif
      lat = 1;
      forever begin
         #1;
         if (result_ready || lat >= 20) break;
         if (lat == 2) begin
            check({tag, "_hold"}, result, last_result);
            multiplicand = 22'($urandom);
            orgmul       = 4'($urandom);
         end
         @(negedge clk);
         lat++;
      end
      check({tag, "_latency"}, lat, exp_lat);
      check({tag, "_result"}, result, exp_res);
      check({tag, "_overflow"}, overflow, exp_ovf);
      if (roundtrip && b != 0 && (p >> 22) == 0)
         check({tag, "_quotient"}, result / b, a);
      last_result = exp_res;
   endtask

   initial begin
      logic [21:0] ra;
      logic [3:0]  rb;
      reset = 1'b1;
      start = 1'b0;
      multiplicand = '0;
      orgmul = '0;
      #12;
      check("reset_result", result, 0);
      check("reset_overflow", overflow, 0);
      @(negedge clk);
      reset = 1'b0;
      #1 check("ready_after_reset", result_ready, 1);

      start_op(22'd12345, 4'd7, 1);
      finish_op("basic", 22'd12345, 4'd7, 0);
      start_op(22'h2AAAAA, 4'd0, 1);
      finish_op("zero", 22'h2AAAAA, 4'd0, 0);
      start_op(22'h2AAAAA, 4'd1, 1);
      finish_op("one", 22'h2AAAAA, 4'd1, 0);
      start_op(22'h3FFFFF, 4'd15, 1);
      finish_op("max", 22'h3FFFFF, 4'd15, 0);

      // Restart: second start at t+5 abandons (1000,15)
      start_op(22'd1000, 4'd15, 1);
      repeat (3) begin
         @(negedge clk);
         #1 check("restart_busy", result_ready, 0);
      end
      start_op(22'd3, 4'd3, 1);
      finish_op("restart", 22'd3, 4'd3, 0);

      start_op(22'd500, 4'd9, 3);
      finish_op("held_start", 22'd500, 4'd9, 0);

      start_op(22'd12345, 4'd7, 1);
      finish_op("pre_reset", 22'd12345, 4'd7, 0);
      @(posedge clk);
      #3 reset = 1'b1;
      #1;
      check("async_reset_result", result, 0);
      check("async_reset_overflow", overflow, 0);
      @(negedge clk);
      reset = 1'b0;
      #1 check("ready_after_async_reset", result_ready, 1);
      last_result = '0;

      for (int n = 0; n < 200; n++) begin
         ra = 22'($urandom);
         if ($urandom_range(0, 1) == 1) ra = ra >> $urandom_range(0, 21);
         rb = 4'($urandom_range(0, 15));
         start_op(ra, rb, 1);
         finish_op("random", ra, rb, 1);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
